sort_job_scheduler: RTL and testbench
=====================================

Name: sort_job_scheduler

Overview:
- Shares one sequential odd-even transposition sort engine among R requesters.
- Round-robin grants the engine to one requester at a time. The granted requester streams in N words. The block sorts them ascending, one pass per cycle, then streams them out tagged with the requester id.
- Reports the number of sort passes each job used. This replaces the zero-time loop-based sorting, so timing comparisons are measured in real clock cycles.

Parameters:
- N, 8, words per job (N >= 2)
- W, 32, word width (unsigned)
- R, 4, number of requesters (R >= 2)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req  input  R  per-requester job request (level)
- grant  output  R  one-hot owner of the engine; all-zero when idle
- in_valid  input  R  per-requester input word valid
- in_data  input  R*W  per-requester input word; requester r uses bits [r*W +: W]
- in_ready  output  R  input ready; only the granted bit can be 1
- out_valid  output  1  sorted word valid
- out_data  output  W  sorted word
- out_id  output  clog2(R)  requester id of the current job
- out_last  output  1  marks the final (N-1th) output word
- out_ready  input  1  downstream ready
- busy  output  1  engine owned (state != IDLE)
- sort_cycles  output  clog2(N)+1  passes used by the last completed sort; valid from the first DRAIN cycle until the next job's SORT starts

Behaviour:
- Reset values:
  - grant, in_ready, out_valid, out_last, busy, sort_cycles, out_data and out_id are all 0.
  - Buffer contents are don't-care; state is IDLE; the round-robin pointer gives priority to requester 0.
- States are IDLE, LOAD, SORT and DRAIN. All transitions are registered.
- IDLE:
  - When req != 0, select the first set bit at or after the pointer, wrapping around.
  - Next cycle: grant is one-hot for that requester, out_id holds its id, state is LOAD.
  - The pointer is set to the granted index + 1 (mod R).
  - If req == 0, remain in IDLE.
- LOAD:
  - in_ready[g] = 1 only for the granted requester g; all other bits are 0.
  - Each in_valid[g] & in_ready[g] handshake writes buf[cnt] and increments cnt.
  - On the handshake with cnt == N-1, go to SORT; in_ready drops the next cycle.
  - Deasserting req during LOAD is ignored; the job runs to completion.
- SORT:
  - Pass p (starting at 0) runs one pass per cycle, with all compare-swaps in parallel.
  - Even p compares pairs (0,1), (2,3), ...; odd p compares pairs (1,2), (3,4), ....
  - A pair swaps only if buf[lo] > buf[lo+1] (unsigned). Equal values never swap.
  - The engine tracks whether each pass swapped anything.
  - Exit after pass p when either:
    - p >= 1 and neither pass p nor pass p-1 swapped, or
    - p == N-1.
  - On exit, sort_cycles = p+1 and state goes to DRAIN.
  - Cost is therefore 2..N cycles.
- DRAIN:
  - out_valid = 1 and out_data = buf[idx], where idx starts at 0. out_last = (idx == N-1).
  - On out_valid & out_ready, idx increments.
  - While out_ready is low, out_data, out_id and out_last hold stable.
  - On the last handshake: next cycle is IDLE, grant = 0 and out_valid = 0. No new grant is issued in that same cycle; a new grant comes at the earliest one cycle later.
- Simultaneous requests are resolved only in IDLE, by round-robin. Requests arriving in other states wait.
- Reset mid-operation:
  - Asynchronously returns all outputs to their reset values and the state to IDLE.
  - The pointer returns to requester 0. A partial job is discarded.
- Throughput for one job: N load cycles + 2..N sort cycles + N drain cycles (with out_ready high) + 1 grant cycle.

Decomposition:
- Shared package sort_pkg holds:
  - the state enum (IDLE, LOAD, SORT, DRAIN),
  - a localparam helper for the id width (clog2(R)),
  - a count-width function (clog2(N)+1).
- One sub-module: sort_oet_pass.
  - Combinational, one transposition pass.
  - Inputs: N×W vector and a phase bit. Outputs: the passed vector and a swapped flag.
- The scheduler owns the FSM, arbiter, buffer, counters and output mux.

Test Plan (N=4, W=8, R=2):
1. Hold rst, then release -> all outputs 0 and busy=0. Pulse rst while idle -> no change.
2. req[0] with data 4,3,2,1 -> grant=01; outputs 1,2,3,4 with out_id=0 and out_last on 4; sort_cycles=4.
3. req[1] with data 1,2,3,4 -> sort_cycles=2. Data 5,5,2,5 -> outputs 2,5,5,5.
4. req=11 held continuously after reset -> grants go 01, 10, 01; out_id sequence 0, 1, 0.
5. Drive out_ready low for 3 cycles during DRAIN word 1 -> out_data=2 is held stable, no word is skipped, and out_last appears only on 4.
6. Assert rst during SORT of job 9,8,7,6 -> outputs reset immediately. Then req[1] with 3,1,2,0 -> outputs 0,1,2,3 with out_id=1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and width helpers for the sort job scheduler and its transposition pass.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DRAIN
    } state_t;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_W = 32;
    localparam int DEFAULT_R = 4;

    function automatic int id_width(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // Wide enough to hold N itself, which the pass count can reach.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sort_job_scheduler_if.sv
// Requester/downstream bundle of the sort job scheduler; the scheduler sits on the slave side.
interface sort_job_scheduler_if #(
    parameter int N = 8,
    parameter int W = 32,
    parameter int R = 4
);
    import sort_pkg::*;

    localparam int IDW = id_width(R);
    localparam int CW  = cnt_width(N);

    logic [R-1:0]   req;
    logic [R-1:0]   grant;
    logic [R-1:0]   in_valid;
    logic [R*W-1:0] in_data;
    logic [R-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_last;
    logic           out_ready;
    logic           busy;
    logic [CW-1:0]  sort_cycles;

    modport master (
        output req, in_valid, in_data, out_ready,
        input  grant, in_ready, out_valid, out_data, out_id, out_last, busy, sort_cycles
    );

    modport slave (
        input  req, in_valid, in_data, out_ready,
        output grant, in_ready, out_valid, out_data, out_id, out_last, busy, sort_cycles
    );

endinterface

// File: rtl/sort_oet_pass.sv
// One odd-even transposition pass: phase 0 compares pairs (0,1),(2,3)..., phase 1 compares (1,2),(3,4)...
module sort_oet_pass #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic [N*W-1:0] data_in,
    input  logic           phase,
    output logic [N*W-1:0] data_out,
    output logic           swapped
);

    // Pairs of one phase never overlap, so every swap reads the untouched input.
    always_comb begin
        data_out = data_in;
        swapped  = 1'b0;
        for (int lo = 0; lo < N - 1; lo++) begin
            if (lo[0] == phase) begin
                if (data_in[lo*W +: W] > data_in[(lo+1)*W +: W]) begin
                    data_out[lo*W +: W]     = data_in[(lo+1)*W +: W];
                    data_out[(lo+1)*W +: W] = data_in[lo*W +: W];
                    swapped                 = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sort_job_scheduler.sv
// Round-robin scheduler sharing one odd-even transposition sort engine among R requesters.
// A granted job loads N words, sorts one pass per clock, then drains tagged with the owner's id.
module sort_job_scheduler
    import sort_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32,
    parameter int R = 4
) (
    input  logic clk,
    input  logic rst,
    sort_job_scheduler_if.slave bus
);

    localparam int IDW = id_width(R);
    localparam int CW  = cnt_width(N);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [R-1:0]   grant_q;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  pass_idx;
    logic [CW-1:0]  sort_cycles_q;
    logic           prev_swapped;
    logic [N*W-1:0] buf_q;
    logic [N*W-1:0] pass_out;
    logic           swapped;
    logic [IDW-1:0] sel;
    logic           sel_found;
    logic           cnt_last;
    logic           load_fire;
    logic           sort_done;
    logic           drain_fire;
    logic [W-1:0]   in_word;

    sort_oet_pass #(
        .N (N),
        .W (W)
    ) u_pass (
        .data_in  (buf_q),
        .phase    (pass_idx[0]),
        .data_out (pass_out),
        .swapped  (swapped)
    );

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (!sel_found && bus.req[(int'(ptr) + k) % R]) begin
                sel_found = 1'b1;
                sel       = IDW'((int'(ptr) + k) % R);
            end
        end
    end

    assign in_word    = bus.in_data[int'(owner)*W +: W];
    assign cnt_last   = (cnt == CW'(N - 1));
    assign load_fire  = (state == LOAD) && bus.in_valid[owner];
    assign drain_fire = (state == DRAIN) && bus.out_ready;
    assign sort_done  = (state == SORT) &&
                        (((pass_idx != '0) && !swapped && !prev_swapped) ||
                         (pass_idx == CW'(N - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = '0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (sel_found) state_next = LOAD;
            end
            LOAD: begin
                bus.in_ready = grant_q;
                if (load_fire && cnt_last) state_next = SORT;
            end
            SORT: begin
                if (sort_done) state_next = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                bus.out_last  = cnt_last;
                bus.out_data  = buf_q[int'(cnt)*W +: W];
                if (drain_fire && cnt_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // cnt serves as the load write index and later as the drain read index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            owner         <= '0;
            grant_q       <= '0;
            cnt           <= '0;
            pass_idx      <= '0;
            prev_swapped  <= 1'b0;
            sort_cycles_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner   <= sel;
                        grant_q <= R'(1) << sel;
                        ptr     <= (sel == IDW'(R - 1)) ? '0 : sel + 1'b1;
                        cnt     <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) begin
                            pass_idx     <= '0;
                            prev_swapped <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    pass_idx     <= pass_idx + 1'b1;
                    prev_swapped <= swapped;
                    if (sort_done) sort_cycles_q <= pass_idx + 1'b1;
                end
                DRAIN: begin
                    if (drain_fire) begin
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) grant_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffer contents are meaningless outside a job, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load_fire)           buf_q[int'(cnt)*W +: W] <= in_word;
        else if (state == SORT)  buf_q <= pass_out;
    end

    assign bus.grant       = grant_q;
    assign bus.out_id      = owner;
    assign bus.sort_cycles = sort_cycles_q;

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Self-checking bench for sort_job_scheduler: directed plan steps plus randomized jobs vs a reference model.
module tb_sort_job_scheduler;
    import sort_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
    localparam int R = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int rr_ptr   = 0;

    sort_job_scheduler_if #(.N(N), .W(W), .R(R)) bus ();

    sort_job_scheduler #(.N(N), .W(W), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester at or after the pointer.
    function automatic int model_grant(input logic [R-1:0] r, input int p);
        for (int k = 0; k < R; k++)
            if (r[(p + k) % R]) return (p + k) % R;
        return -1;
    endfunction

    function automatic void ref_sorted(input logic [7:0] d [N], output logic [7:0] s [N]);
        logic [7:0] t;
        s = d;
        for (int i = 1; i < N; i++)
            for (int j = i; j > 0; j--)
                if (s[j-1] > s[j]) begin
                    t = s[j-1]; s[j-1] = s[j]; s[j] = t;
                end
    endfunction

    // Pass count from the exit rule: two clean passes in a row, or N passes.
    function automatic int model_passes(input logic [7:0] d [N]);
        logic [7:0] a [N];
        logic [7:0] t;
        bit sw;
        bit prev_sw;
        a = d;
        prev_sw = 1'b1;
        for (int p = 0; p < N; p++) begin
            sw = 1'b0;
            for (int lo = p % 2; lo + 1 < N; lo += 2)
                if (a[lo] > a[lo+1]) begin
                    t = a[lo]; a[lo] = a[lo+1]; a[lo+1] = t; sw = 1'b1;
                end
            if (p >= 1 && !sw && !prev_sw) return p + 1;
            prev_sw = sw;
        end
        return N;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_grant"}, bus.grant, 0);
        checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
        checkOutput({tag, "_out_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_out_last"}, bus.out_last, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_sort_cycles"}, bus.sort_cycles, 0);
        checkOutput({tag, "_out_data"}, bus.out_data, 0);
        checkOutput({tag, "_out_id"}, bus.out_id, 0);
    endtask

    task automatic waitGrant(input logic [R-1:0] req_pat, output int g, output bit ok);
        int n;
        g = model_grant(req_pat, rr_ptr);
        bus.req = req_pat;
        n = 0;
        while (bus.grant == '0 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("grant", bus.grant, 1 << g);
        checkOutput("grant_id", bus.out_id, g);
        checkOutput("grant_busy", bus.busy, 1);
        ok = (bus.grant != '0);
        rr_ptr = (g + 1) % R;
    endtask

    task automatic loadWords(input int g, input logic [7:0] d [N]);
        for (int i = 0; i < N; i++) begin
            bus.in_data = (R*W)'($urandom);
            bus.in_data[g*W +: W] = d[i];
            bus.in_valid = '0;
            bus.in_valid[(g + 1) % R] = 1'($urandom_range(0, 1));
            bus.in_valid[g] = 1'b1;
            checkOutput("in_ready", bus.in_ready, 1 << g);
            tick();
        end
        bus.in_valid = '0;
        checkOutput("in_ready_drop", bus.in_ready, 0);
    endtask

    task automatic applyStimulus(input logic [R-1:0] req_pat,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3,
                                 input int stall_word, input int stall_len, input bit drop_req);
        logic [7:0] d [N];
        logic [7:0] exp_s [N];
        int exp_passes;
        int g;
        int n;
        bit ok;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        ref_sorted(d, exp_s);
        exp_passes = model_passes(d);
        waitGrant(req_pat, g, ok);
        if (!ok) return;
        if (drop_req) bus.req = '0;
        loadWords(g, d);
        n = 0;
        while (!bus.out_valid && n < 3 * N) begin
            tick();
            n++;
        end
        checkOutput("sort_latency", n, exp_passes);
        checkOutput("sort_cycles", bus.sort_cycles, exp_passes);
        for (int i = 0; i < N; i++) begin
            if (i == stall_word) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    checkOutput("stall_data", bus.out_data, exp_s[i]);
                    checkOutput("stall_last", bus.out_last, (i == N - 1) ? 1 : 0);
                    checkOutput("stall_id", bus.out_id, g);
                end
                bus.out_ready = 1'b1;
            end
            checkOutput("out_valid", bus.out_valid, 1);
            checkOutput("out_data", bus.out_data, exp_s[i]);
            checkOutput("out_last", bus.out_last, (i == N - 1) ? 1 : 0);
            checkOutput("out_id", bus.out_id, g);
            tick();
        end
        checkOutput("end_out_valid", bus.out_valid, 0);
        checkOutput("end_grant", bus.grant, 0);
        checkOutput("end_busy", bus.busy, 0);
    endtask

    initial begin
        int g;
        bit ok;
        logic [7:0] ad [N];

        bus.req       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset hold, release, and an idle reset pulse.
        tick();
        tick();
        checkResetOutputs("reset_hold");
        rst = 1'b0;
        tick();
        checkResetOutputs("reset_release");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkResetOutputs("idle_pulse");

        // Reverse order uses every pass; sorted input exits after two; equal values stay put.
        applyStimulus(2'b01, 8'd4, 8'd3, 8'd2, 8'd1, N, 0, 1'b1);
        applyStimulus(2'b10, 8'd1, 8'd2, 8'd3, 8'd4, N, 0, 1'b1);
        applyStimulus(2'b10, 8'd5, 8'd5, 8'd2, 8'd5, N, 0, 1'b0);

        // Continuous contention right after reset alternates owners.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_ptr = 0;
        applyStimulus(2'b11, 8'd7, 8'd0, 8'd9, 8'd3, N, 0, 1'b0);
        applyStimulus(2'b11, 8'd2, 8'd8, 8'd1, 8'd6, N, 0, 1'b0);
        applyStimulus(2'b11, 8'd200, 8'd100, 8'd255, 8'd0, N, 0, 1'b0);

        // Downstream back-pressure on word 1.
        applyStimulus(2'b01, 8'd4, 8'd3, 8'd2, 8'd1, 1, 3, 1'b1);

        // Reset in the middle of a sort discards the job and rewinds the pointer.
        ad[0] = 8'd9; ad[1] = 8'd8; ad[2] = 8'd7; ad[3] = 8'd6;
        waitGrant(2'b01, g, ok);
        bus.req = '0;
        if (ok) loadWords(g, ad);
        tick();
        checkOutput("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        tick();
        rst = 1'b0;
        rr_ptr = 0;
        applyStimulus(2'b11, 8'd11, 8'd22, 8'd3, 8'd44, N, 0, 1'b1);
        applyStimulus(2'b10, 8'd3, 8'd1, 8'd2, 8'd0, N, 0, 1'b1);

        // Randomized jobs: request mix, small value range for duplicates, random stalls.
        for (int j = 0; j < 10; j++) begin
            applyStimulus(2'($urandom_range(1, 3)),
                          8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                          8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                          int'($urandom_range(0, N)), int'($urandom_range(1, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
